// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared constants and types for the uart_tx_dev UART transmitter
// Contents: system address map slot, register word offsets, STATUS/CTRL bit
// indices, the transmit FSM state enum and the bit-period reload helper.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).
package uart_tx_pkg;

  // Device slot on the simple-system bus: 1 kB window at 0x40000.
  localparam logic [31:0] UartBaseAddr = 32'h0004_0000;
  localparam logic [31:0] UartAddrMask = ~32'h0000_03FF;

  // Register word offsets (addr[9:2]).
  localparam logic [7:0] RegTxData  = 8'h00;
  localparam logic [7:0] RegStatus  = 8'h01;
  localparam logic [7:0] RegCtrl    = 8'h02;
  localparam logic [7:0] RegBaudDiv = 8'h03;

  // STATUS bit indices; fill count occupies bits [7:4].
  localparam int unsigned StatusFullBit  = 0;
  localparam int unsigned StatusEmptyBit = 1;
  localparam int unsigned StatusBusyBit  = 2;

  // CTRL bit indices.
  localparam int unsigned CtrlTxEnBit  = 0;
  localparam int unsigned CtrlIrqEnBit = 1;
  localparam int unsigned CtrlParEnBit = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } uart_tx_state_e;

  // Down-counter reload for one bit period; a divider of 0 behaves as 1.
  function automatic logic [15:0] baud_reload(input logic [15:0] div);
    return (div == 16'd0) ? 16'd0 : div - 16'd1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO buffering bytes awaiting transmission
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset (empties the FIFO)
//   push, push_data  enqueue a byte; ignored while full
//   pop            dequeue the head; ignored while empty
//   head           byte at the read pointer
//   full, empty, count  occupancy, all from the registered count
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [7:0]             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

  logic [7:0]      mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic            do_push;
  logic            do_pop;

  // Full/empty come from the count at the start of the cycle, so a pop in
  // the same cycle never makes room for a push.
  assign full    = (count == DepthCnt);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + (PtrW + 1)'(1);
      end else if (do_pop && !do_push) begin
        count <= count - (PtrW + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_dev.sv
// rtl/uart_tx_dev.sv - memory-mapped 8N1 UART transmitter with TX FIFO and drain interrupt
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   uart_req_i/we_i/be_i/addr_i/wdata_i  device-side bus request (offset = addr[9:2])
//   uart_rvalid_o/rdata_o/err_o          response, one cycle after each request
//   tx_o               serial line, idle high
//   uart_intr_o        level interrupt: irq_en & FIFO empty & FSM idle, registered
// Registers: 0x0 TXDATA (W), 0x1 STATUS (RO), 0x2 CTRL (RW), 0x3 BAUD_DIV (RW).
// Optional feature macro: UART_TX_PARITY_EN (CTRL.par_en and an even-parity bit).
module uart_tx_dev
  import uart_tx_pkg::*;
#(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32,
  parameter int unsigned FifoDepth      = 8,
  parameter int unsigned DefaultBaudDiv = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    uart_req_i,
  input  logic                    uart_we_i,
  input  logic [3:0]              uart_be_i,
  input  logic [AddressWidth-1:0] uart_addr_i,
  input  logic [DataWidth-1:0]    uart_wdata_i,
  output logic                    uart_rvalid_o,
  output logic [DataWidth-1:0]    uart_rdata_o,
  output logic                    uart_err_o,
  output logic                    tx_o,
  output logic                    uart_intr_o
);
  localparam int unsigned CntW = $clog2(FifoDepth) + 1;

  // Control/configuration registers.
  logic        tx_en;
  logic        irq_en;
  logic [15:0] baud_div;
`ifdef UART_TX_PARITY_EN
  logic        par_en;
  logic        parity_bit;
`endif

  // FIFO interface.
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [7:0]      fifo_head;
  logic [CntW-1:0] fifo_count;

  // Transmit datapath.
  uart_tx_state_e state;
  logic [15:0]    baud_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           bit_done;
  logic           frame_ready;
  logic [15:0]    bit_reload;

  // Bus decode.
  logic [7:0]           offset;
  logic [DataWidth-1:0] rd_data;
  logic                 bus_err;
  logic                 ctrl_we;
  logic                 baud_we;
  logic [7:0]           status_byte;
  logic [7:0]           ctrl_byte;
  logic [3:0]           fill_sat;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{uart_addr_i[AddressWidth-1:10], uart_addr_i[1:0],
                             uart_wdata_i[DataWidth-1:16], uart_be_i[3:2]};

  assign offset = uart_addr_i[9:2];

  uart_tx_fifo #(
    .Depth(FifoDepth)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push     (fifo_push),
    .push_data(uart_wdata_i[7:0]),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign fill_sat = (32'(fifo_count) > 32'd15) ? 4'hF : 4'(fifo_count);

  always_comb begin
    status_byte                 = 8'h00;
    status_byte[StatusFullBit]  = fifo_full;
    status_byte[StatusEmptyBit] = fifo_empty;
    status_byte[StatusBusyBit]  = (state != StIdle);
    status_byte[7:4]            = fill_sat;
  end

  always_comb begin
    ctrl_byte               = 8'h00;
    ctrl_byte[CtrlTxEnBit]  = tx_en;
    ctrl_byte[CtrlIrqEnBit] = irq_en;
`ifdef UART_TX_PARITY_EN
    ctrl_byte[CtrlParEnBit] = par_en;
`endif
  end

  // Erroring accesses must leave all state untouched, so every side effect
  // below is gated by a decode that cannot also raise bus_err.
  always_comb begin
    rd_data   = '0;
    bus_err   = 1'b0;
    fifo_push = 1'b0;
    ctrl_we   = 1'b0;
    baud_we   = 1'b0;
    if (uart_req_i) begin
      case (offset)
        RegTxData: begin
          if (uart_we_i && uart_be_i[0]) begin
            if (fifo_full) begin
              bus_err = 1'b1;
            end else begin
              fifo_push = 1'b1;
            end
          end
        end
        RegStatus: begin
          if (uart_we_i) begin
            bus_err = 1'b1;
          end else begin
            rd_data[7:0] = status_byte;
          end
        end
        RegCtrl: begin
          if (uart_we_i) begin
            ctrl_we = 1'b1;
          end else begin
            rd_data[7:0] = ctrl_byte;
          end
        end
        RegBaudDiv: begin
          if (uart_we_i) begin
            baud_we = 1'b1;
          end else begin
            rd_data[15:0] = baud_div;
          end
        end
        default: bus_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      uart_rvalid_o <= 1'b0;
      uart_rdata_o  <= '0;
      uart_err_o    <= 1'b0;
      uart_intr_o   <= 1'b0;
      tx_en         <= 1'b0;
      irq_en        <= 1'b0;
      baud_div      <= 16'(DefaultBaudDiv);
`ifdef UART_TX_PARITY_EN
      par_en        <= 1'b0;
`endif
    end else begin
      uart_rvalid_o <= uart_req_i;
      uart_rdata_o  <= rd_data;
      uart_err_o    <= bus_err;
      uart_intr_o   <= irq_en & fifo_empty & (state == StIdle);
      if (ctrl_we && uart_be_i[0]) begin
        tx_en  <= uart_wdata_i[CtrlTxEnBit];
        irq_en <= uart_wdata_i[CtrlIrqEnBit];
`ifdef UART_TX_PARITY_EN
        par_en <= uart_wdata_i[CtrlParEnBit];
`endif
      end
      if (baud_we && uart_be_i[0]) begin
        baud_div[7:0] <= uart_wdata_i[7:0];
      end
      if (baud_we && uart_be_i[1]) begin
        baud_div[15:8] <= uart_wdata_i[15:8];
      end
    end
  end

  // baud_cnt counts the remaining cycles of the current bit; it is reloaded
  // from the live BAUD_DIV at every bit boundary, which is what makes a
  // mid-frame divider change take effect on the next bit.
  assign bit_done    = (baud_cnt == 16'd0);
  assign bit_reload  = baud_reload(baud_div);
  assign frame_ready = tx_en & ~fifo_empty;
  // Head is popped in the cycle the FSM commits to a new START, from IDLE or
  // straight out of STOP so back-to-back frames have no idle gap.
  assign fifo_pop    = frame_ready & ((state == StIdle) || (state == StStop && bit_done));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= StIdle;
      tx_o     <= 1'b1;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      if (state != StIdle && !bit_done) begin
        baud_cnt <= baud_cnt - 16'd1;
      end
      case (state)
        StIdle: begin
          if (frame_ready) begin
            state    <= StStart;
            tx_o     <= 1'b0;
            shreg    <= fifo_head;
            baud_cnt <= bit_reload;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^fifo_head;
`endif
          end
        end
        StStart: begin
          if (bit_done) begin
            state    <= StData;
            tx_o     <= shreg[0];
            shreg    <= {1'b0, shreg[7:1]};
            bit_idx  <= 3'd0;
            baud_cnt <= bit_reload;
          end
        end
        StData: begin
          if (bit_done) begin
            baud_cnt <= bit_reload;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              if (par_en) begin
                state <= StParity;
                tx_o  <= parity_bit;
              end else begin
                state <= StStop;
                tx_o  <= 1'b1;
              end
`else
              state <= StStop;
              tx_o  <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_o    <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (bit_done) begin
            state    <= StStop;
            tx_o     <= 1'b1;
            baud_cnt <= bit_reload;
          end
        end
`endif
        StStop: begin
          if (bit_done) begin
            if (frame_ready) begin
              state    <= StStart;
              tx_o     <= 1'b0;
              shreg    <= fifo_head;
              baud_cnt <= bit_reload;
`ifdef UART_TX_PARITY_EN
              parity_bit <= ^fifo_head;
`endif
            end else begin
              state <= StIdle;
              tx_o  <= 1'b1;
            end
          end
        end
        default: begin
          state <= StIdle;
          tx_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_dev.md
Name: uart_tx_dev

Overview:
- Memory-mapped UART transmitter on the simple-system bus, one device slot next to SimCtrl and Timer (base 0x40000, 1 kB window).
- Consumes device-side bus requests (req/we/be/addr/wdata) and returns rvalid/rdata/err.
- Buffers written bytes in a FIFO and serialises them 8N1 on a single output line.
- Raises a level interrupt when transmission drains.

Parameters:
- DataWidth, 32, bus data width; only 32 supported.
- AddressWidth, 32, bus address width.
- FifoDepth, 8, TX FIFO entries; power of two, >= 2.
- DefaultBaudDiv, 16, reset value of BAUD_DIV.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset; sampled on rising clk_i edge
- uart_req_i  in  1  bus request, single-cycle, always granted
- uart_we_i  in  1  write enable
- uart_be_i  in  4  byte enables
- uart_addr_i  in  AddressWidth  byte address; offset = addr[9:2]
- uart_wdata_i  in  DataWidth  write data
- uart_rvalid_o  out  1  response valid, one cycle after req
- uart_rdata_o  out  DataWidth  read data, valid with rvalid
- uart_err_o  out  1  error response, valid with rvalid
- tx_o  out  1  serial line, idle high
- uart_intr_o  out  1  level interrupt

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low (rst_ni).
- Reset values:
  - rvalid=0, rdata=0, err=0, tx_o=1, intr=0.
  - FIFO empty, FSM IDLE.
  - CTRL=0, BAUD_DIV=DefaultBaudDiv.
- Registers, word offsets:
  - 0x0 TXDATA: W pushes wdata[7:0]; read returns 0.
  - 0x1 STATUS: RO. bit0 full, bit1 empty, bit2 busy (FSM != IDLE), bits[7:4] fill count (saturating at 15).
  - 0x2 CTRL: RW. bit0 tx_en, bit1 irq_en.
  - 0x3 BAUD_DIV: RW, bits[15:0].
- Bus response:
  - Every req produces rvalid exactly the next cycle.
  - err=1 for an unmapped offset or a write to STATUS. No state change on err.
  - Partial byte enables: a byte lane is written only if its be bit is set.
  - TXDATA push requires be[0]; be[0]=0 is a no-op with no error.
- FIFO:
  - Push on a TXDATA write while full: byte dropped, err=1.
  - Full is evaluated on the pre-cycle count. A simultaneous pop does not make room in the same cycle.
  - Simultaneous push and pop on a non-full FIFO: count unchanged, order preserved.
  - Pointers wrap modulo FifoDepth.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when tx_en=1 and FIFO non-empty. Pop the head into the shift register; tx_o=0 next cycle.
  - Each bit lasts max(BAUD_DIV,1) cycles; BAUD_DIV=0 is treated as 1.
  - DATA sends 8 bits, LSB first.
  - STOP drives tx_o=1 for one bit period.
  - STOP -> START if FIFO non-empty and tx_en=1, otherwise -> IDLE. Frames are back-to-back with no idle gap.
  - Clearing tx_en mid-frame: the current frame completes, then IDLE.
  - BAUD_DIV written mid-frame: takes effect at the next bit boundary.
- Interrupt: intr = irq_en & FIFO empty & FSM IDLE, registered (1-cycle latency).
- Reset mid-frame: tx_o returns to 1 on the cycle after the reset edge and the FIFO is discarded.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- With it:
  - CTRL bit2 par_en becomes RW.
  - When par_en=1, a PARITY state is inserted between DATA and STOP, sending even parity (XOR of the 8 data bits) for one bit period.
- Without it:
  - CTRL bit2 reads 0 and writes are ignored.
  - No PARITY state exists in the FSM.

Decomposition:
- Shared package uart_tx_pkg:
  - register offset constants;
  - FSM state enum uart_tx_state_e;
  - STATUS/CTRL bit-index constants;
  - base address 0x40000 and mask ~0x3FF for the system address map.
- One sub-module, uart_tx_fifo:
  - synchronous FIFO with push/pop/full/empty/count;
  - FifoDepth parameter;
  - same clk_i/rst_ni.

Test Plan:
- Reset then read STATUS: rdata=0x00000002 (empty); read BAUD_DIV: 16; tx_o=1; intr=0.
- BAUD_DIV=2, tx_en=1, write TXDATA=0xA5: tx_o sequence per 2-cycle bit is 0,1,0,1,0,0,1,0,1,1. Exactly 20 cycles from START entry to the end of STOP.
- Write 9 bytes with tx_en=0 and FifoDepth=8: the first 8 get err=0, the 9th gets err=1. STATUS then reads full=1, count=8.
- Write offset 0x1 (STATUS) and offset 0x10: both give err=1 and no register change. Read offset 0x10: err=1.
- irq_en=1, tx_en=1, BAUD_DIV=1, two bytes written back-to-back: no idle gap between frames. intr rises 1 cycle after the second STOP completes.
- Reset asserted mid-DATA with 3 bytes queued: the cycle after the reset edge, tx_o=1 and STATUS=0x2. No further frames start.
